// File: rtl/mgt_init_pkg.sv
// Shared definitions for the GTX bring-up sequencer: state encoding exported
// to the software status register and the per-state reset pattern.
package mgt_init_pkg;

  localparam int STATE_W = 4;

  typedef enum logic [STATE_W-1:0] {
    ST_IDLE       = 4'd0,
    ST_CPLL_RST   = 4'd1,
    ST_CPLL_WAIT  = 4'd2,
    ST_TX_RST     = 4'd3,
    ST_TX_WAIT    = 4'd4,
    ST_RX_RST     = 4'd5,
    ST_RX_WAIT    = 4'd6,
    ST_ALIGN_WAIT = 4'd7,
    ST_READY      = 4'd8,
    ST_FAULT      = 4'd9
  } initState_e;

  // {cpllreset, gttxreset, gtrxreset} held while resident in a state; a block
  // stays in reset until its own reset pulse has completed.
  function automatic logic [2:0] resetsFor(input initState_e st);
    logic [2:0] pattern;
    case (st)
      ST_CPLL_WAIT, ST_TX_RST:              pattern = 3'b011;
      ST_TX_WAIT, ST_RX_RST:                pattern = 3'b001;
      ST_RX_WAIT, ST_ALIGN_WAIT, ST_READY:  pattern = 3'b000;
      default:                              pattern = 3'b111;
    endcase
    return pattern;
  endfunction

endpackage

// File: rtl/mgt_init_sequencer_if.sv
// Control/status bundle between the bring-up sequencer and the MGT wrapper side.
interface mgt_init_sequencer_if;
  import mgt_init_pkg::*;

  logic               start;
  logic               autoRestart;
  logic               cplllock;
  logic               txresetdone;
  logic               rxresetdone;
  logic               rxIsAligned;
  logic               cpllreset;
  logic               gttxreset;
  logic               gtrxreset;
  logic               ready;
  logic               fault;
  logic [STATE_W-1:0] state;
  logic [2:0]         retryCount;

  modport master (
    input  start, autoRestart, cplllock, txresetdone, rxresetdone, rxIsAligned,
    output cpllreset, gttxreset, gtrxreset, ready, fault, state, retryCount
  );

  modport slave (
    output start, autoRestart, cplllock, txresetdone, rxresetdone, rxIsAligned,
    input  cpllreset, gttxreset, gtrxreset, ready, fault, state, retryCount
  );

endinterface

// File: rtl/sync_bit.sv
// Two-flop synchronizer for one asynchronous status bit, reset to 0.
module sync_bit (
  input  logic clk,
  input  logic arstN,
  input  logic d,
  output logic q
);

  logic meta_r;
  logic q_r;

  // Settling pair; the second flop is the only one the consumer sees.
  always_ff @(posedge clk or negedge arstN) begin
    if (!arstN) begin
      meta_r <= 1'b0;
      q_r    <= 1'b0;
    end else begin
      meta_r <= d;
      q_r    <= meta_r;
    end
  end

  assign q = q_r;

endmodule

// File: rtl/mgt_init_sequencer.sv
// GTX bring-up sequencer: CPLL/TX/RX resets in order, status supervision,
// bounded full-sequence retries and a sticky fault.
module mgt_init_sequencer
  import mgt_init_pkg::*;
#(
  parameter int RESET_CYCLES   = 128,
  parameter int TIMEOUT_CYCLES = 1000000,
  parameter int MAX_RETRIES    = 3,
  parameter int TIMER_WIDTH    = 24
) (
  input  logic                 sysClk,
  input  logic                 sysReset_n,
  mgt_init_sequencer_if.master bus
);

  localparam logic [TIMER_WIDTH-1:0] RESET_LAST   = TIMER_WIDTH'(RESET_CYCLES - 1);
  localparam logic [TIMER_WIDTH-1:0] TIMEOUT_LAST = TIMER_WIDTH'(TIMEOUT_CYCLES - 1);
  localparam logic [TIMER_WIDTH-1:0] TIMER_ONE    = TIMER_WIDTH'(1);
  localparam logic [2:0]             RETRY_MAX    = 3'(MAX_RETRIES);

  logic cplllock_s;
  logic txDone_s;
  logic rxDone_s;
  logic aligned_s;

  sync_bit uSyncLock    (.clk(sysClk), .arstN(sysReset_n), .d(bus.cplllock),    .q(cplllock_s));
  sync_bit uSyncTxDone  (.clk(sysClk), .arstN(sysReset_n), .d(bus.txresetdone), .q(txDone_s));
  sync_bit uSyncRxDone  (.clk(sysClk), .arstN(sysReset_n), .d(bus.rxresetdone), .q(rxDone_s));
  sync_bit uSyncAligned (.clk(sysClk), .arstN(sysReset_n), .d(bus.rxIsAligned), .q(aligned_s));

  initState_e             state_r;
  initState_e             stateNext_s;
  initState_e             retryState_s;
  logic [TIMER_WIDTH-1:0] timer_r;
  logic [2:0]             retry_r;
  logic [2:0]             retryNext_s;
  logic [2:0]             retryBump_s;
  logic                   resetDone_s;
  logic                   timeout_s;
  logic                   retryExhausted_s;
  logic                   allGood_s;
  logic                   cpllreset_r;
  logic                   gttxreset_r;
  logic                   gtrxreset_r;
  logic                   ready_r;
  logic                   fault_r;

  assign resetDone_s      = (timer_r == RESET_LAST);
  assign timeout_s        = (timer_r == TIMEOUT_LAST);
  assign allGood_s        = cplllock_s & txDone_s & rxDone_s & aligned_s;
  // A timeout either restarts the whole sequence or, once out of retries, faults.
  assign retryExhausted_s = (retry_r == RETRY_MAX);
  assign retryState_s     = retryExhausted_s ? ST_FAULT : ST_CPLL_RST;
  assign retryBump_s      = retryExhausted_s ? retry_r : (retry_r + 3'd1);

  // Next-state decode; start overrides everything, a met condition beats a timeout.
  always_comb begin
    stateNext_s = state_r;
    retryNext_s = retry_r;
    if (bus.start) begin
      stateNext_s = ST_CPLL_RST;
      retryNext_s = 3'd0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          stateNext_s = ST_IDLE;
        end
        ST_CPLL_RST: begin
          if (resetDone_s) stateNext_s = ST_CPLL_WAIT;
          else             stateNext_s = ST_CPLL_RST;
        end
        ST_CPLL_WAIT: begin
          if (cplllock_s) begin
            stateNext_s = ST_TX_RST;
          end else if (timeout_s) begin
            stateNext_s = retryState_s;
            retryNext_s = retryBump_s;
          end else begin
            stateNext_s = ST_CPLL_WAIT;
          end
        end
        ST_TX_RST: begin
          if (resetDone_s) stateNext_s = ST_TX_WAIT;
          else             stateNext_s = ST_TX_RST;
        end
        ST_TX_WAIT: begin
          if (txDone_s) begin
            stateNext_s = ST_RX_RST;
          end else if (timeout_s) begin
            stateNext_s = retryState_s;
            retryNext_s = retryBump_s;
          end else begin
            stateNext_s = ST_TX_WAIT;
          end
        end
        ST_RX_RST: begin
          if (resetDone_s) stateNext_s = ST_RX_WAIT;
          else             stateNext_s = ST_RX_RST;
        end
        ST_RX_WAIT: begin
          if (rxDone_s) begin
            stateNext_s = ST_ALIGN_WAIT;
          end else if (timeout_s) begin
            stateNext_s = retryState_s;
            retryNext_s = retryBump_s;
          end else begin
            stateNext_s = ST_RX_WAIT;
          end
        end
        ST_ALIGN_WAIT: begin
          if (aligned_s) begin
            stateNext_s = ST_READY;
          end else if (timeout_s) begin
            stateNext_s = retryState_s;
            retryNext_s = retryBump_s;
          end else begin
            stateNext_s = ST_ALIGN_WAIT;
          end
        end
        ST_READY: begin
          // Runtime recovery restarts only as far back as the lost resource.
          if (!bus.autoRestart)            stateNext_s = ST_READY;
          else if (!cplllock_s)            stateNext_s = ST_CPLL_RST;
          else if (!txDone_s)              stateNext_s = ST_TX_RST;
          else if (!rxDone_s || !aligned_s) stateNext_s = ST_RX_RST;
          else                             stateNext_s = ST_READY;
        end
        ST_FAULT: begin
          stateNext_s = ST_FAULT;
        end
        default: begin
          stateNext_s = ST_IDLE;
        end
      endcase
    end
  end

  // State, timer and registered outputs; outputs are decoded from the next state.
  always_ff @(posedge sysClk or negedge sysReset_n) begin
    if (!sysReset_n) begin
      state_r     <= ST_IDLE;
      timer_r     <= '0;
      retry_r     <= 3'd0;
      cpllreset_r <= 1'b1;
      gttxreset_r <= 1'b1;
      gtrxreset_r <= 1'b1;
      ready_r     <= 1'b0;
      fault_r     <= 1'b0;
    end else begin
      state_r <= stateNext_s;
      retry_r <= retryNext_s;
      if ((stateNext_s != state_r) || bus.start) begin
        timer_r <= '0;
      end else if (timer_r != '1) begin
        timer_r <= timer_r + TIMER_ONE;
      end else begin
        timer_r <= timer_r;
      end
      {cpllreset_r, gttxreset_r, gtrxreset_r} <= resetsFor(stateNext_s);
      ready_r <= (state_r == ST_READY) && (stateNext_s == ST_READY) && allGood_s;
      fault_r <= (stateNext_s == ST_FAULT);
    end
  end

  assign bus.cpllreset  = cpllreset_r;
  assign bus.gttxreset  = gttxreset_r;
  assign bus.gtrxreset  = gtrxreset_r;
  assign bus.ready      = ready_r;
  assign bus.fault      = fault_r;
  assign bus.state      = state_r;
  assign bus.retryCount = retry_r;

endmodule

// File: tb/tb_mgt_init_sequencer.sv
// Directed bench for mgt_init_sequencer with short reset/timeout parameters.
module tb_mgt_init_sequencer;
  import mgt_init_pkg::*;

  logic sysClk;
  logic sysReset_n;
  int   passCount;
  int   failCount;
  int   totalCount;
  int   n;

  mgt_init_sequencer_if bus ();

  mgt_init_sequencer #(
    .RESET_CYCLES  (4),
    .TIMEOUT_CYCLES(64),
    .MAX_RETRIES   (2),
    .TIMER_WIDTH   (8)
  ) dut (
    .sysClk    (sysClk),
    .sysReset_n(sysReset_n),
    .bus       (bus)
  );

  initial sysClk = 1'b0;
  always #5 sysClk = ~sysClk;

  task automatic tick();
    @(posedge sysClk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    totalCount++;
    assert (obs === exp) passCount++;
    else begin
      failCount++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic waitState(input logic [3:0] target, input int budget, input string tag);
    int k;
    k = 0;
    while (bus.state !== target && k < budget) begin
      tick();
      k++;
    end
    check(tag, 32'(bus.state), 32'(target));
  endtask

  task automatic pulseStart();
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
  endtask

  initial begin
    passCount  = 0;
    failCount  = 0;
    totalCount = 0;
    sysReset_n = 1'b0;
    bus.start       = 1'b0;
    bus.autoRestart = 1'b0;
    bus.cplllock    = 1'b0;
    bus.txresetdone = 1'b0;
    bus.rxresetdone = 1'b0;
    bus.rxIsAligned = 1'b0;
    #12;
    check("rst_state",  32'(bus.state), 32'd0);
    check("rst_resets", 32'({bus.cpllreset, bus.gttxreset, bus.gtrxreset}), 32'h7);
    check("rst_ready",  32'(bus.ready), 32'd0);
    check("rst_fault",  32'(bus.fault), 32'd0);
    check("rst_retry",  32'(bus.retryCount), 32'd0);
    sysReset_n = 1'b1;
    repeat (3) tick();
    check("idle_hold", 32'(bus.state), 32'd0);

    // Nominal bring-up
    pulseStart();
    n = 0;
    while (bus.state == 4'd1 && bus.cpllreset == 1'b1 && n < 20) begin
      n++;
      tick();
    end
    check("cpll_pulse_len", 32'(n), 32'd4);
    check("cpll_wait_state", 32'(bus.state), 32'd2);
    check("cpll_wait_resets", 32'({bus.cpllreset, bus.gttxreset, bus.gtrxreset}), 32'h3);
    repeat (10) tick();
    bus.cplllock = 1'b1;
    waitState(4'd4, 30, "reach_tx_wait");
    check("tx_wait_resets", 32'({bus.cpllreset, bus.gttxreset, bus.gtrxreset}), 32'h1);
    bus.txresetdone = 1'b1;
    waitState(4'd6, 30, "reach_rx_wait");
    check("rx_wait_resets", 32'({bus.cpllreset, bus.gttxreset, bus.gtrxreset}), 32'h0);
    bus.rxresetdone = 1'b1;
    waitState(4'd7, 30, "reach_align_wait");
    bus.rxIsAligned = 1'b1;
    waitState(4'd8, 30, "reach_ready");
    check("ready_entry_low", 32'(bus.ready), 32'd0);
    tick();
    check("ready_high", 32'(bus.ready), 32'd1);
    check("ready_retry", 32'(bus.retryCount), 32'd0);
    check("ready_fault", 32'(bus.fault), 32'd0);

    // Lock loss with autoRestart
    bus.autoRestart = 1'b1;
    bus.cplllock    = 1'b0;
    tick();
    tick();
    check("lockloss_sync_delay", 32'(bus.state), 32'd8);
    tick();
    check("lockloss_state", 32'(bus.state), 32'd1);
    check("lockloss_cpllreset", 32'(bus.cpllreset), 32'd1);
    check("lockloss_ready", 32'(bus.ready), 32'd0);
    check("lockloss_retry", 32'(bus.retryCount), 32'd0);
    waitState(4'd2, 20, "relock_cpll_wait");
    repeat (10) tick();
    bus.cplllock = 1'b1;
    waitState(4'd8, 60, "relock_ready_state");
    tick();
    check("relock_ready", 32'(bus.ready), 32'd1);

    // Lock loss without autoRestart
    bus.autoRestart = 1'b0;
    bus.cplllock    = 1'b0;
    tick();
    tick();
    check("noauto_ready_lag", 32'(bus.ready), 32'd1);
    tick();
    check("noauto_ready_low", 32'(bus.ready), 32'd0);
    repeat (5) tick();
    check("noauto_state", 32'(bus.state), 32'd8);
    bus.cplllock = 1'b1;
    repeat (3) tick();
    check("noauto_ready_back", 32'(bus.ready), 32'd1);

    // CPLL never locks: two retries then fault
    bus.cplllock    = 1'b0;
    bus.txresetdone = 1'b0;
    bus.rxresetdone = 1'b0;
    bus.rxIsAligned = 1'b0;
    pulseStart();
    for (int r = 1; r <= 3; r++) begin
      waitState(4'd2, 20, "nolock_cpll_wait");
      n = 0;
      while (bus.state == 4'd2 && n < 100) begin
        n++;
        tick();
      end
      check("nolock_timeout_len", 32'(n), 32'd64);
      if (r < 3) begin
        check("nolock_retry_state", 32'(bus.state), 32'd1);
        check("nolock_retry_count", 32'(bus.retryCount), 32'(r));
      end else begin
        check("fault_state", 32'(bus.state), 32'd9);
      end
    end
    check("fault_flag", 32'(bus.fault), 32'd1);
    check("fault_resets", 32'({bus.cpllreset, bus.gttxreset, bus.gtrxreset}), 32'h7);
    check("fault_retry", 32'(bus.retryCount), 32'd2);
    repeat (5) tick();
    check("fault_sticky", 32'(bus.fault), 32'd1);

    // Leave fault, one retry, then abort from TX_WAIT
    pulseStart();
    check("unfault_state", 32'(bus.state), 32'd1);
    check("unfault_flag", 32'(bus.fault), 32'd0);
    check("unfault_retry", 32'(bus.retryCount), 32'd0);
    waitState(4'd2, 20, "abort_cpll_wait");
    waitState(4'd1, 100, "abort_retry_state");
    check("abort_retry_one", 32'(bus.retryCount), 32'd1);
    bus.cplllock = 1'b1;
    waitState(4'd4, 40, "abort_tx_wait");
    pulseStart();
    check("abort_state", 32'(bus.state), 32'd1);
    check("abort_retry_zero", 32'(bus.retryCount), 32'd0);

    // Asynchronous reset during RX_WAIT
    bus.txresetdone = 1'b1;
    waitState(4'd6, 60, "arst_rx_wait");
    sysReset_n = 1'b0;
    #1;
    check("arst_state", 32'(bus.state), 32'd0);
    check("arst_resets", 32'({bus.cpllreset, bus.gttxreset, bus.gtrxreset}), 32'h7);
    check("arst_ready_fault", 32'({bus.ready, bus.fault}), 32'd0);
    sysReset_n = 1'b1;
    repeat (6) tick();
    check("arst_stays_idle", 32'(bus.state), 32'd0);

    $display("%0d/%0d checks passed", passCount, totalCount);
    $finish;
  end

endmodule
